// File: rtl/booth_mul_r4.sv
// Radix-4 Booth sequential multiplier: two multiplier bits retired per CALC cycle.
// Optional early termination when the remaining Booth digits are all zero: define BOOTH_EARLY_TERM_EN.
module booth_mul_r4 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 stall,
  output logic                 finish
);

  localparam int M  = WIDTH + 2;        // extended operand width
  localparam int N  = M / 2;            // Booth digits per operation
  localparam int AW = 2 * M + 2;        // accumulator width
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [M-1:0]   a_q, a_d;
  logic signed [M:0]     b_q, b_d;      // extended multiplier with y(-1) in bit 0
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;

  logic signed [M+1:0]   hi_sum;
  logic signed [AW-1:0]  acc_sh;
  logic signed [AW-1:0]  acc_fin;
  logic signed [M:0]     b_sh;
  logic                  done_now;

  function automatic logic signed [M+1:0] booth_pp(input logic [2:0] sel,
                                                   input logic signed [M-1:0] a);
    logic signed [M+1:0] ax;
    ax = {{2{a[M-1]}}, a};
    case (sel)
      3'b001, 3'b010: booth_pp = ax;
      3'b011:         booth_pp = ax <<< 1;
      3'b100:         booth_pp = -(ax <<< 1);
      3'b101, 3'b110: booth_pp = -ax;
      default:        booth_pp = '0;
    endcase
  endfunction

  // Partial product enters at the top of the accumulator, then everything shifts right by 2.
  always_comb begin
    hi_sum = $signed(acc_q[AW-1:M]) + booth_pp(b_q[2:0], a_q);
    acc_sh = $signed({hi_sum, acc_q[M-1:0]}) >>> 2;
    b_sh   = b_q >>> 2;
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [CW:0] shamt;

  // Once the remaining multiplier bits are all equal every later digit is zero,
  // so the outstanding shifts are applied in one go.
  always_comb begin
    shamt    = {LAST - cnt_q, 1'b0};
    done_now = (cnt_q == LAST) || (b_sh == '0) || (&b_sh);
    acc_fin  = acc_sh >>> shamt;
  end
`else
  always_comb begin
    done_now = (cnt_q == LAST);
    acc_fin  = acc_sh;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          a_d     = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
          b_d     = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                                : {2'b00, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        b_d   = b_sh;
        acc_d = acc_fin;
        cnt_d = cnt_q + 1'b1;
        if (done_now) begin
          prod_d  = acc_fin[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign product = prod_q;
  assign finish  = (state_q == DONE);

endmodule

// File: tb/tb_booth_mul_r4.sv
// Directed checks of booth_mul_r4 at WIDTH=32 and WIDTH=8; latency expectations follow BOOTH_EARLY_TERM_EN.
module tb_booth_mul_r4;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st32, sm32, stl32, fin32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        st8, sm8, stl8, fin8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  booth_mul_r4 #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(st32), .signed_mode(sm32),
    .multiplicand(a32), .multiplier(b32),
    .product(p32), .stall(stl32), .finish(fin32)
  );

  booth_mul_r4 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .product(p8), .stall(stl8), .finish(fin8)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One request; lat is the cycle (edge E0 = end of cycle 0) in which finish is seen, -1 on timeout.
  task automatic run_op(input bit w8, input logic sm, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] prod, output bit stall_ok);
    bit s, f;
    @(negedge clk);
    if (w8) begin st8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin st32 = 1'b1; sm32 = sm; a32 = a; b32 = b; end
    #1;
    stall_ok = w8 ? stl8 : stl32;
    @(posedge clk);
    #1;
    st8 = 1'b0; st32 = 1'b0;
    a8 = ~a8; b8 = ~b8; sm8 = ~sm8;
    a32 = ~a32; b32 = ~b32; sm32 = ~sm32;
    lat  = -1;
    prod = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      s = w8 ? stl8 : stl32;
      f = w8 ? fin8 : fin32;
      if (f) begin
        lat  = cyc;
        prod = w8 ? {48'b0, p8} : p32;
        if (s) stall_ok = 1'b0;
        break;
      end
      if (!s) stall_ok = 1'b0;
    end
  endtask

  typedef struct packed {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  initial begin
    int          lat, first, second, nfin;
    logic [63:0] prod, p1, p2;
    bit          sok;
    vec_t        v32[5];
    vec_t        v8[4];
    logic [7:0]  ra, rb;
    logic        rsm;
    int          ia, ib;
    logic [15:0] e16;

    v32[0] = '{1'b1, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB};
    v32[1] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    v32[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    v32[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
    v32[4] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    v8[0]  = '{1'b1, 32'h80, 32'h80, 64'h4000};
    v8[1]  = '{1'b0, 32'hFF, 32'hFF, 64'hFE01};
    v8[2]  = '{1'b1, 32'hFF, 32'hFF, 64'h0001};
    v8[3]  = '{1'b1, 32'h80, 32'h7F, 64'hC080};

    rst = 1'b1;
    st32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    st8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("rst_product", p32, 64'h0);
    check("rst_finish", {63'b0, fin32}, 64'h0);
    check("rst_stall", {63'b0, stl32}, 64'h0);
    check("rst_product8", {48'b0, p8}, 64'h0);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'd100, 32'd100, lat, prod, sok);
    check("u100x100_product", prod, 64'd10000);
    check("u100x100_latency", 64'(lat), ET ? 64'd5 : 64'd18);
    check("u100x100_stall", {63'b0, sok}, 64'h1);
    repeat (3) @(negedge clk);
    check("hold_product", p32, 64'd10000);
    check("hold_finish", {63'b0, fin32}, 64'h0);

    foreach (v32[i]) begin
      run_op(1'b0, v32[i].sm, v32[i].a, v32[i].b, lat, prod, sok);
      check($sformatf("w32_vec%0d_product", i), prod, v32[i].exp);
      check($sformatf("w32_vec%0d_done", i), {63'b0, lat > 0}, 64'h1);
      if (!ET) check($sformatf("w32_vec%0d_latency", i), 64'(lat), 64'd18);
    end

    // start held high with new operands while the first pair is computing
    @(negedge clk);
    st32 = 1'b1; sm32 = 1'b0; a32 = 32'd3; b32 = 32'd4;
    @(posedge clk);
    #1;
    a32 = 32'd5; b32 = 32'd6;
    nfin = 0; first = -1; second = -1; p1 = '0; p2 = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (fin32) begin
        nfin++;
        if (nfin == 1) begin first = cyc; p1 = p32; end
        else begin second = cyc; p2 = p32; st32 = 1'b0; break; end
      end
    end
    st32 = 1'b0;
    check("held_first_product", p1, 64'd12);
    check("held_second_product", p2, 64'd30);
    check("held_second_after_idle", {63'b0, (first > 0) && (second >= first + 2)}, 64'h1);
    if (!ET) begin
      check("held_first_cycle", 64'(first), 64'd18);
      check("held_second_cycle", 64'(second), 64'd37);
    end

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    st32 = 1'b1; sm32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h0765_4321;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", {63'b0, stl32}, 64'h0);
    check("midrst_finish", {63'b0, fin32}, 64'h0);
    check("midrst_product", p32, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b0, 32'd5, 32'd6, lat, prod, sok);
    check("after_rst_product", prod, 64'd30);
    if (!ET) check("after_rst_latency", 64'(lat), 64'd18);

    foreach (v8[i]) begin
      run_op(1'b1, v8[i].sm, v8[i].a, v8[i].b, lat, prod, sok);
      check($sformatf("w8_vec%0d_product", i), prod, v8[i].exp);
      if (!ET) check($sformatf("w8_vec%0d_latency", i), 64'(lat), 64'd6);
    end

    for (int k = 0; k < 1000; k++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom);
      ia  = rsm ? int'($signed(ra)) : int'(ra);
      ib  = rsm ? int'($signed(rb)) : int'(rb);
      e16 = 16'(ia * ib);
      run_op(1'b1, rsm, {24'b0, ra}, {24'b0, rb}, lat, prod, sok);
      check($sformatf("w8_rand%0d_%s_%h_%h", k, rsm ? "s" : "u", ra, rb), prod, {48'b0, e16});
      if (!ET) check($sformatf("w8_rand%0d_latency", k), 64'(lat), 64'd6);
      else     check($sformatf("w8_rand%0d_done", k), {63'b0, lat > 0}, 64'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
